// File: rtl/tetromino_fetch.sv
// Tetromino fetch: range-checks random codes, reads shapes from BRAM, buffers current + next piece.
// Optional TETROMINO_NO_REPEAT_EN rerolls a code that repeats the last fetched piece once.
module tetromino_fetch #(
    parameter int MEM_AWIDTH = 4,
    parameter int SHAPE_W    = 16,
    parameter int NUM_PIECES = 7
) (
    input  logic                  i_pixclk,
    input  logic                  i_reset_n,
    input  logic [MEM_AWIDTH-1:0] i_random_address,
    input  logic                  i_clear,
    output logic                  o_mem_en,
    output logic [MEM_AWIDTH-1:0] o_mem_addr,
    input  logic [SHAPE_W-1:0]    i_mem_data,
    output logic                  o_piece_valid,
    input  logic                  i_piece_ready,
    output logic [2:0]            o_piece_id,
    output logic [SHAPE_W-1:0]    o_piece_shape,
    output logic                  o_next_valid,
    output logic [2:0]            o_next_id
);

    typedef enum logic [1:0] {SAMPLE, READ, CAPTURE} state_t;

    localparam logic [MEM_AWIDTH-1:0] NUM_CODES = MEM_AWIDTH'(NUM_PIECES);

    state_t             state;
    state_t             state_next;
    logic [SHAPE_W-1:0] next_shape;
    logic               code_ok;
    logic               repeat_hit;
    logic               accept;
    logic               handshake;
    logic               transfer;

`ifdef TETROMINO_NO_REPEAT_EN
    logic [MEM_AWIDTH-1:0] last_id;
    logic                  last_valid;
    logic                  rerolled;
`endif

    always_comb begin
        code_ok    = (i_random_address < NUM_CODES);
`ifdef TETROMINO_NO_REPEAT_EN
        repeat_hit = last_valid && (i_random_address == last_id) && !rerolled;
`else
        repeat_hit = 1'b0;
`endif
        accept     = (state == SAMPLE) && !o_next_valid && code_ok && !repeat_hit;
        handshake  = o_piece_valid && i_piece_ready;
        transfer   = o_next_valid && (!o_piece_valid || i_piece_ready);
    end

    always_comb begin
        state_next = state;
        case (state)
            SAMPLE:  if (accept) state_next = READ;
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = SAMPLE;
            default: state_next = SAMPLE;
        endcase
    end

    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n || i_clear) state <= SAMPLE;
        else                       state <= state_next;
    end

    // o_mem_addr doubles as the candidate register: it holds the accepted code until CAPTURE.
    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            o_mem_en      <= 1'b0;
            o_mem_addr    <= '0;
            o_piece_valid <= 1'b0;
            o_piece_id    <= '0;
            o_piece_shape <= '0;
            o_next_valid  <= 1'b0;
            o_next_id     <= '0;
            next_shape    <= '0;
`ifdef TETROMINO_NO_REPEAT_EN
            last_id       <= '0;
            last_valid    <= 1'b0;
            rerolled      <= 1'b0;
`endif
        end else if (i_clear) begin
            o_mem_en      <= 1'b0;
            o_piece_valid <= 1'b0;
            o_next_valid  <= 1'b0;
`ifdef TETROMINO_NO_REPEAT_EN
            last_valid    <= 1'b0;
            rerolled      <= 1'b0;
`endif
        end else begin
            o_mem_en <= accept;
            if (accept) o_mem_addr <= i_random_address;

            if (state == CAPTURE) begin
                o_next_valid <= 1'b1;
                o_next_id    <= 3'(o_mem_addr);
                next_shape   <= i_mem_data;
            end else if (transfer) begin
                o_next_valid <= 1'b0;
            end

            if (transfer) begin
                o_piece_valid <= 1'b1;
                o_piece_id    <= o_next_id;
                o_piece_shape <= next_shape;
            end else if (handshake) begin
                o_piece_valid <= 1'b0;
            end

`ifdef TETROMINO_NO_REPEAT_EN
            if (state == CAPTURE) begin
                last_id    <= o_mem_addr;
                last_valid <= 1'b1;
            end
            if (accept)
                rerolled <= 1'b0;
            else if (state == SAMPLE && !o_next_valid && code_ok && repeat_hit)
                rerolled <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_tetromino_fetch.sv
// Bench for tetromino_fetch: directed timing checks plus randomized traffic scored against a queue model.
module tb_tetromino_fetch;

    localparam int AW = 4;
    localparam int SW = 16;
    localparam int NP = 7;

    typedef struct {
        int            id;
        logic [SW-1:0] shape;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          ready;
    logic [AW-1:0] code;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_data = '0;
    logic          piece_valid;
    logic [2:0]    piece_id;
    logic [SW-1:0] piece_shape;
    logic          next_valid;
    logic [2:0]    next_id;
    logic [SW-1:0] rom [16];

    int checks = 0;
    int passes = 0;

    // Reference model: slot occupancy, fetch age (0 idle, 1 read issued, 2 data due), expected pieces.
    bit   m_cur_v  = 1'b0;
    bit   m_nxt_v  = 1'b0;
    bit   m_last_v = 1'b0;
    bit   m_reroll = 1'b0;
    int   m_age    = 0;
    int   m_cand   = 0;
    int   m_nxt_id = 0;
    int   m_last   = 0;
    exp_t expq[$];

    tetromino_fetch #(.MEM_AWIDTH(AW), .SHAPE_W(SW), .NUM_PIECES(NP)) dut (
        .i_pixclk         (clk),
        .i_reset_n        (rst_n),
        .i_random_address (code),
        .i_clear          (clear),
        .o_mem_en         (mem_en),
        .o_mem_addr       (mem_addr),
        .i_mem_data       (mem_data),
        .o_piece_valid    (piece_valid),
        .i_piece_ready    (ready),
        .o_piece_id       (piece_id),
        .o_piece_shape    (piece_shape),
        .o_next_valid     (next_valid),
        .o_next_id        (next_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_data <= rom[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    task automatic model_step();
        bit old_nxt;
        bit hs;
        bit rej;
        exp_t e;
        if (!rst_n || clear) begin
            m_cur_v = 0; m_nxt_v = 0; m_last_v = 0; m_reroll = 0; m_age = 0;
            expq.delete();
        end else begin
            old_nxt = m_nxt_v;
            hs = m_cur_v && ready;
            if (m_nxt_v && (!m_cur_v || hs)) begin
                m_cur_v = 1; m_nxt_v = 0;
            end else if (hs) begin
                m_cur_v = 0;
            end
            if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2) begin
                m_age = 0; m_nxt_v = 1; m_nxt_id = m_cand; m_last = m_cand; m_last_v = 1;
            end else if (!old_nxt && int'(code) < NP) begin
                rej = 0;
`ifdef TETROMINO_NO_REPEAT_EN
                rej = m_last_v && int'(code) == m_last && !m_reroll;
`endif
                if (rej) begin
                    m_reroll = 1;
                end else begin
                    m_reroll = 0; m_age = 1; m_cand = int'(code);
                    e.id = int'(code); e.shape = rom[code];
                    expq.push_back(e);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: flags every cycle; a handshake about to happen pops the expected piece.
    initial forever begin
        exp_t e;
        @(negedge clk);
        chk("piece_valid", {31'd0, piece_valid}, {31'd0, m_cur_v});
        chk("next_valid", {31'd0, next_valid}, {31'd0, m_nxt_v});
        chk("mem_en", {31'd0, mem_en}, (m_age == 1) ? 32'd1 : 32'd0);
        if (m_age == 1) chk("mem_addr", 32'(mem_addr), m_cand);
        if (m_nxt_v) chk("next_id", 32'(next_id), m_nxt_id);
        if (rst_n && !clear && piece_valid === 1'b1 && ready) begin
            if (expq.size() == 0) begin
                checks++;
                $display("FAIL scoreboard: piece id %0d presented with no expected piece", piece_id);
            end else begin
                e = expq.pop_front();
                chk("sb_piece_id", 32'(piece_id), e.id);
                chk("sb_piece_shape", 32'(piece_shape), 32'(e.shape));
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic rd, input logic [AW-1:0] cd);
        rst_n = r; clear = c; ready = rd; code = cd;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_piece_valid"}, {31'd0, piece_valid}, 0);
        chk({tag, "_piece_id"}, 32'(piece_id), 0);
        chk({tag, "_piece_shape"}, 32'(piece_shape), 0);
        chk({tag, "_next_valid"}, {31'd0, next_valid}, 0);
        chk({tag, "_next_id"}, 32'(next_id), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = SW'($urandom) ^ SW'(i);
        rst_n = 0; clear = 0; ready = 0; code = '0;

        // Reset state, then first fetch with code 3 and a refill with code 6.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_all_zero("reset");
        step(1, 0, 0, 3);
        chk("e1_mem_en", {31'd0, mem_en}, 1);
        chk("e1_mem_addr", 32'(mem_addr), 3);
        step(1, 0, 0, 3);
        chk("e2_mem_en", {31'd0, mem_en}, 0);
        step(1, 0, 0, 3);
        chk("e3_next_valid", {31'd0, next_valid}, 1);
        chk("e3_piece_valid", {31'd0, piece_valid}, 0);
        step(1, 0, 0, 3);
        chk("e4_piece_valid", {31'd0, piece_valid}, 1);
        chk("e4_piece_id", 32'(piece_id), 3);
        chk("e4_piece_shape", 32'(piece_shape), 32'(rom[3]));
        chk("e4_next_valid", {31'd0, next_valid}, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 6);
        chk("e7_next_valid", {31'd0, next_valid}, 1);
        chk("e7_next_id", 32'(next_id), 6);

        // Both slots full: a one-cycle handshake promotes next into current.
        step(1, 0, 1, 1);
        chk("hs_piece_valid", {31'd0, piece_valid}, 1);
        chk("hs_piece_id", 32'(piece_id), 6);
        chk("hs_piece_shape", 32'(piece_shape), 32'(rom[6]));
        chk("hs_next_valid", {31'd0, next_valid}, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("refill_early", {31'd0, next_valid}, 0);
        step(1, 0, 0, 1);
        chk("refill_next_valid", {31'd0, next_valid}, 1);
        chk("refill_next_id", 32'(next_id), 1);

        // Out-of-range codes are rejected until a valid one arrives.
        step(1, 1, 0, 0);
        chk("clear_piece_valid", {31'd0, piece_valid}, 0);
        step(1, 0, 0, 15);
        chk("rej15_mem_en", {31'd0, mem_en}, 0);
        step(1, 0, 0, 9);
        chk("rej9_mem_en", {31'd0, mem_en}, 0);
        step(1, 0, 0, 7);
        chk("rej7_mem_en", {31'd0, mem_en}, 0);
        step(1, 0, 0, 2);
        chk("acc2_mem_en", {31'd0, mem_en}, 1);
        chk("acc2_mem_addr", 32'(mem_addr), 2);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 15);
        chk("acc2_piece_valid", {31'd0, piece_valid}, 1);
        chk("acc2_piece_id", 32'(piece_id), 2);

        // Clear during READ discards the in-flight fetch.
        step(1, 1, 0, 0);
        step(1, 0, 0, 4);
        chk("rd_mem_en", {31'd0, mem_en}, 1);
        step(1, 1, 0, 4);
        chk("clr_rd_mem_en", {31'd0, mem_en}, 0);
        chk("clr_rd_piece_valid", {31'd0, piece_valid}, 0);
        chk("clr_rd_next_valid", {31'd0, next_valid}, 0);
        step(1, 0, 0, 5);
        chk("after_clr_mem_en", {31'd0, mem_en}, 1);
        chk("after_clr_mem_addr", 32'(mem_addr), 5);
        step(1, 0, 0, 15);
        step(1, 0, 0, 15);
        chk("after_clr_next_id", 32'(next_id), 5);
        step(1, 0, 0, 15);
        chk("after_clr_piece_id", 32'(piece_id), 5);
        chk("after_clr_piece_shape", 32'(piece_shape), 32'(rom[5]));

        // Reset held for two cycles while in CAPTURE.
        step(1, 1, 0, 0);
        step(1, 0, 0, 2);
        step(1, 0, 0, 2);
        step(0, 0, 0, 2);
        step(0, 0, 0, 2);
        chk_all_zero("rst_cap");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 2);
        chk("rst_cap_e3_piece_valid", {31'd0, piece_valid}, 0);
        step(1, 0, 0, 2);
        chk("rst_cap_e4_piece_valid", {31'd0, piece_valid}, 1);
        chk("rst_cap_e4_piece_id", 32'(piece_id), 2);

        // Constant code 5: repeat handling decides when the second piece lands.
        step(0, 0, 0, 5);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 5);
        chk("rep_piece_id", 32'(piece_id), 5);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 5);
`ifdef TETROMINO_NO_REPEAT_EN
        chk("rep_e7_next_valid", {31'd0, next_valid}, 0);
`else
        chk("rep_e7_next_valid", {31'd0, next_valid}, 1);
`endif
        step(1, 0, 0, 5);
        chk("rep_e8_next_valid", {31'd0, next_valid}, 1);
        chk("rep_e8_next_id", 32'(next_id), 5);

        // Randomized traffic against the model and scoreboard.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 255) != 0), ($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
        end
        step(1, 0, 0, 15);
        step(1, 0, 0, 15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
